// File: rtl/seg_display_reader.sv
// ============================================================================
// Module   : seg_display_reader
// Brief    : Reads one memory word, converts q[15:0] (signed) to five decimal
//            digits plus sign on 7-segment outputs. Define HEX_MODE_EN to show
//            q[15:0] as four hex digits instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_reader (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rd_addr,
    output logic [7:0]  address,
    output logic        wren,
    input  logic [31:0] q,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [6:0]  seg_neg
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] CONV = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [6:0] C_SEG_ZERO = 7'b1111110;
    localparam logic [6:0] C_SEG_NEG  = 7'b0000001;

    logic [2:0] r_state;
    logic       w_unused_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Only the low half-word is displayed; the upper half is intentionally dropped.
    assign w_unused_q = ^q[31:16];
    assign wren       = 1'b0;
    assign busy       = (r_state != IDLE);

`ifdef HEX_MODE_EN

    logic [15:0] r_hex;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
            address <= 8'd0;
            done    <= 1'b0;
            r_hex   <= 16'd0;
            seg0    <= C_SEG_ZERO;
            seg1    <= C_SEG_ZERO;
            seg2    <= C_SEG_ZERO;
            seg3    <= C_SEG_ZERO;
            seg4    <= C_SEG_ZERO;
            seg_neg <= 7'b0000000;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        address <= rd_addr;
                        r_state <= RD0;
                    end
                end
                RD0:  r_state <= RD1;
                RD1:  r_state <= CAP;
                CAP: begin
                    r_hex   <= q[15:0];
                    r_state <= DONE;
                end
                DONE: begin
                    seg0    <= hex_to_seg(r_hex[3:0]);
                    seg1    <= hex_to_seg(r_hex[7:4]);
                    seg2    <= hex_to_seg(r_hex[11:8]);
                    seg3    <= hex_to_seg(r_hex[15:12]);
                    seg4    <= C_SEG_ZERO;
                    seg_neg <= 7'b0000000;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`else

    // {bcd[19:0], binary[15:0]} double-dabble shift register
    logic [35:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_sign;
    logic [15:0] w_mag;

    function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Two's-complement negate; 0x8000 maps onto itself, read as 32768 unsigned.
    assign w_mag = q[15] ? (16'd0 - q[15:0]) : q[15:0];

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
            address <= 8'd0;
            done    <= 1'b0;
            r_shift <= 36'd0;
            r_cnt   <= 4'd0;
            r_sign  <= 1'b0;
            seg0    <= C_SEG_ZERO;
            seg1    <= C_SEG_ZERO;
            seg2    <= C_SEG_ZERO;
            seg3    <= C_SEG_ZERO;
            seg4    <= C_SEG_ZERO;
            seg_neg <= 7'b0000000;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        address <= rd_addr;
                        r_state <= RD0;
                    end
                end
                RD0:  r_state <= RD1;
                RD1:  r_state <= CAP;
                CAP: begin
                    r_sign  <= q[15];
                    r_shift <= {20'd0, w_mag};
                    r_cnt   <= 4'd0;
                    r_state <= CONV;
                end
                CONV: begin
                    r_shift <= {dabble_adjust(r_shift[35:16]), r_shift[15:0]} << 1;
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15)
                        r_state <= DONE;
                end
                DONE: begin
                    seg0    <= hex_to_seg(r_shift[19:16]);
                    seg1    <= hex_to_seg(r_shift[23:20]);
                    seg2    <= hex_to_seg(r_shift[27:24]);
                    seg3    <= hex_to_seg(r_shift[31:28]);
                    seg4    <= hex_to_seg(r_shift[35:32]);
                    seg_neg <= r_sign ? C_SEG_NEG : 7'b0000000;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_display_reader.sv
// ============================================================================
// Module   : tb_seg_display_reader
// Brief    : Randomized self-checking bench with an arithmetic display model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_reader;

    logic        clock;
    logic        rst;
    logic        start;
    logic [7:0]  rd_addr;
    logic [7:0]  address;
    logic        wren;
    logic [31:0] q;
    logic        busy;
    logic        done;
    logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg_neg;

`ifdef HEX_MODE_EN
    localparam int LAT    = 4;
    localparam int MID    = 2;
    localparam int RST_AT = 2;
`else
    localparam int LAT    = 20;
    localparam int MID    = 8;
    localparam int RST_AT = 10;
`endif

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic [31:0] p1;

    seg_display_reader dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .rd_addr (rd_addr),
        .address (address),
        .wren    (wren),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .seg0    (seg0),
        .seg1    (seg1),
        .seg2    (seg2),
        .seg3    (seg3),
        .seg4    (seg4),
        .seg_neg (seg_neg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory with two clocks of read latency
    always @(posedge clock) begin
        p1 <= mem[address];
        q  <= p1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) check("wren", {31'd0, wren}, 32'd0);

    // {seg_neg, seg4, seg3, seg2, seg1, seg0}
    function automatic logic [41:0] model(input logic [31:0] d);
        logic [41:0] r;
`ifdef HEX_MODE_EN
        r = {7'b0000000, 7'b1111110, SEG_TBL[d[15:12]], SEG_TBL[d[11:8]],
             SEG_TBL[d[7:4]], SEG_TBL[d[3:0]]};
`else
        int v, mag, p;
        v = int'(d[15:0]);
        if (v >= 32768) v = v - 65536;
        mag = (v < 0) ? -v : v;
        r = '0;
        r[41:35] = (v < 0) ? 7'b0000001 : 7'b0000000;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[k*7 +: 7] = SEG_TBL[(mag / p) % 10];
            p = p * 10;
        end
`endif
        return r;
    endfunction

    task automatic check_outputs(input logic [41:0] e);
        check("seg0",    {25'd0, seg0},    {25'd0, e[6:0]});
        check("seg1",    {25'd0, seg1},    {25'd0, e[13:7]});
        check("seg2",    {25'd0, seg2},    {25'd0, e[20:14]});
        check("seg3",    {25'd0, seg3},    {25'd0, e[27:21]});
        check("seg4",    {25'd0, seg4},    {25'd0, e[34:28]});
        check("seg_neg", {25'd0, seg_neg}, {25'd0, e[41:35]});
    endtask

    task automatic launch(input logic [7:0] a);
        @(negedge clock);
        start   = 1'b1;
        rd_addr = a;
        @(posedge clock);
    endtask

    // Called just after the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input logic [7:0] a, input logic [31:0] d, input int mid);
        int n;
        bit got;
        n   = 0;
        got = 0;
        @(negedge clock);
        start = 1'b0;
        check("addr", {24'd0, address}, {24'd0, a});
        check("busy_hi", {31'd0, busy}, 32'd1);
        check("done_lo", {31'd0, done}, 32'd0);
        while (!got && n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == mid) begin
                start   = 1'b1;
                rd_addr = ~a;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1;
        end
        check("latency", n, LAT);
        if (got) check_outputs(model(d));
    endtask

    task automatic idle_after(input logic [31:0] d);
        @(negedge clock);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_lo", {31'd0, busy}, 32'd0);
        check_outputs(model(d));
    endtask

    task automatic count_extra(input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) cnt++;
        end
        check("extra_done", cnt, 0);
    endtask

    task automatic single_op(input logic [7:0] a);
        launch(a);
        wait_done(a, mem[a], -1);
        idle_after(mem[a]);
    endtask

    initial begin
        logic [7:0] a, a2;
        p1      = 32'd0;
        q       = 32'd0;
        rst     = 1'b1;
        start   = 1'b0;
        rd_addr = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'h000004D2;
        mem[9] = 32'hFFFFFFFF;
        mem[0] = 32'h00008000;
        mem[1] = 32'h00007FFF;
        mem[2] = 32'h0000BEEF;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_addr", {24'd0, address}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_outputs({7'b0000000, {5{7'b1111110}}});

        // Reset wins over a simultaneous start
        start   = 1'b1;
        rd_addr = 8'h33;
        @(posedge clock);
        @(negedge clock);
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        check("rst_prio_addr", {24'd0, address}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        single_op(8'd5);
        single_op(8'd9);
        single_op(8'd0);
        single_op(8'd1);
        single_op(8'd2);

        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom);
            mem[a] = $urandom;
            single_op(a);
        end

        // Start during conversion must be ignored
        a = 8'd5;
        launch(a);
        wait_done(a, mem[a], MID);
        count_extra(25);
        check("addr_hold", {24'd0, address}, {24'd0, a});
        check_outputs(model(mem[a]));

        // Back-to-back: start during the done cycle
        a  = 8'($urandom);
        a2 = a + 8'd1;
        mem[a]  = $urandom;
        mem[a2] = $urandom;
        launch(a);
        wait_done(a, mem[a], -1);
        start   = 1'b1;
        rd_addr = a2;
        @(posedge clock);
        wait_done(a2, mem[a2], -1);
        idle_after(mem[a2]);

        // Abort mid-operation
        single_op(8'd1);
        launch(8'd9);
        @(negedge clock);
        start = 1'b0;
        for (int n = 1; n < RST_AT; n++) begin
            @(posedge clock);
            @(negedge clock);
        end
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_addr", {24'd0, address}, 32'd0);
        check_outputs({7'b0000000, {5{7'b1111110}}});
        count_extra(30);
        check_outputs({7'b0000000, {5{7'b1111110}}});

        single_op(8'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
